dm_responder: RTL
=================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 128, number of 32-bit words in the array; SHALL be a power of two.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_w  input  1  store request from CPU MEM stage, sampled each rising edge.
REQ-005 Addr_in  input  32  byte address from CPU (ALU result).
REQ-006 Data_in  input  32  store data from CPU; low bits are used for sub-word stores.
REQ-007 dm_ctrl  input  3  access size: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned, 101-111 reserved.
REQ-008 Data_out  output  32  load data to CPU, combinational from Addr_in/dm_ctrl/array.
REQ-009 err_clr  input  1  clears sticky error state at next edge.
REQ-010 misalign_err  output  1  sticky flag, set by any rejected store.
REQ-011 err_addr  output  32  Addr_in of the first rejected store since the last clear.
REQ-012 err_cnt  output  8  rejected-store count, saturating at 0xFF.
REQ-013 store_cnt  output  16  accepted-store count, wraps modulo 2^16.

Function
REQ-014 Word index SHALL be Addr_in[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses alias.
REQ-015 A store SHALL be accepted when mem_w=1, dm_ctrl is not reserved, and the address is aligned.
REQ-016 Alignment rule: word requires Addr_in[1:0]=00; half requires Addr_in[0]=0; byte accesses are always aligned.
REQ-017 An accepted store SHALL update the array at that rising edge and write only the addressed byte lanes.
REQ-018 Accepted store lanes:
- word: all four lanes.
- half: Data_in[15:0] into lanes {1,0} if Addr_in[1]=0, else lanes {3,2}.
- byte: Data_in[7:0] into lane Addr_in[1:0].
- Signed and unsigned variants SHALL store identically.
REQ-019 A rejected store (mem_w=1 with reserved dm_ctrl or misalignment) SHALL leave the array unchanged and SHALL:
- set misalign_err;
- increment err_cnt unless it is 0xFF;
- load err_addr only if misalign_err was 0 before that edge.
REQ-020 Every accepted store SHALL increment store_cnt by 1.
REQ-021 Data_out SHALL be combinational with zero-cycle latency.
- Word/reserved: the full word; Addr_in[1:0] is ignored.
- Half: the lane pair selected by Addr_in[1]; sign-extended for 001, zero-extended for 010.
- Byte: the lane selected by Addr_in[1:0]; sign-extended for 011, zero-extended for 100.
REQ-022 Read-after-write: a load in the cycle after a store SHALL return the new data; a load in the same cycle as a store SHALL return the pre-store data.
REQ-023 Reads SHALL never set error state, because the CPU issues no read strobe.
REQ-024 If err_clr and a rejected store occur at the same edge:
- set wins: misalign_err=1, err_cnt=1, err_addr=current Addr_in.
REQ-025 err_clr alone SHALL clear misalign_err, err_cnt and err_addr to 0 at the edge; store_cnt SHALL be unaffected.

Reset
REQ-026 While reset=1 at an edge, the block SHALL:
- zero all array words, misalign_err, err_addr, err_cnt and store_cnt;
- ignore mem_w and err_clr.
REQ-027 Reset SHALL take priority over a store issued in the same cycle; the store is lost and not counted.
REQ-028 After reset, Data_out SHALL read 0 for every address and mode.

Verification
REQ-029 Reset, then sw 0x8000_00F0 at addr 0x10 -> the next cycle lw 0x10 returns 0x8000_00F0 and store_cnt=1.
REQ-030 Word 0x11223344 at 0x20, then sb 0xAA at 0x23 -> lw 0x20=0xAA223344, lb 0x23=0xFFFFFFAA, lbu 0x23=0x000000AA.
REQ-031 sh 0x8001 at 0x32 over a zero word -> lw 0x30=0x80010000, lh 0x32=0xFFFF8001, lhu 0x32=0x00008001.
REQ-032 sw at 0x41, then sh at 0x53 -> array unchanged, misalign_err=1, err_addr=0x41, err_cnt=2, store_cnt unchanged.
REQ-033 Store at 0x4 and 0x4+4*DEPTH_WORDS alias to the same word; err_clr together with a rejected store at 0x7 -> err_cnt=1, err_addr=0x7.
REQ-034 Assert reset in the same cycle as sw 0xDEADBEEF at 0x0 -> lw 0x0=0 and all counters 0.

Source files
------------

// File: rtl/dm_responder.sv
// Byte-addressable data memory for a CPU MEM stage: sized loads/stores with
// lane masking, sign/zero extension, and sticky tracking of rejected stores.
module dm_responder #(
    parameter int DEPTH_WORDS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] Data_out,
    input  logic        err_clr,
    output logic        misalign_err,
    output logic [31:0] err_addr,
    output logic [7:0]  err_cnt,
    output logic [15:0] store_cnt
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [2:0] CTRL_W  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_HU = 3'b010;
    localparam logic [2:0] CTRL_B  = 3'b011;
    localparam logic [2:0] CTRL_BU = 3'b100;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        misalign_err_q, misalign_err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;

    logic [AW-1:0] idx;
    logic          is_word, is_half, is_byte, is_reserved;
    logic          misaligned, st_accept, st_reject;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   word_rd;
    logic [15:0]   half_rd;
    logic [7:0]    byte_rd;

    // Upper address bits are intentionally dropped so the array aliases.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr_in[31:AW+2];

    assign idx = Addr_in[AW+1:2];

    always_comb begin
        is_word     = (dm_ctrl == CTRL_W);
        is_half     = (dm_ctrl == CTRL_H) || (dm_ctrl == CTRL_HU);
        is_byte     = (dm_ctrl == CTRL_B) || (dm_ctrl == CTRL_BU);
        is_reserved = !(is_word || is_half || is_byte);
        misaligned  = (is_word && (Addr_in[1:0] != 2'b00)) ||
                      (is_half && Addr_in[0]);
        st_accept   = mem_w && !is_reserved && !misaligned;
        st_reject   = mem_w && (is_reserved || misaligned);
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = Data_in;
        if (is_word) begin
            wr_be = 4'b1111;
        end else if (is_half) begin
            wr_be   = Addr_in[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{Data_in[15:0]}};
        end else if (is_byte) begin
            wr_be   = 4'b0001 << Addr_in[1:0];
            wr_data = {4{Data_in[7:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (st_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // A rejected store in the same cycle as a clear restarts the error log.
    always_comb begin
        misalign_err_d = misalign_err_q;
        err_addr_d     = err_addr_q;
        err_cnt_d      = err_cnt_q;
        store_cnt_d    = store_cnt_q + {15'd0, st_accept};
        if (err_clr) begin
            misalign_err_d = 1'b0;
            err_addr_d     = '0;
            err_cnt_d      = '0;
        end
        if (st_reject) begin
            misalign_err_d = 1'b1;
            if (err_clr) begin
                err_cnt_d  = 8'd1;
                err_addr_d = Addr_in;
            end else begin
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                if (!misalign_err_q) begin
                    err_addr_d = Addr_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err_q <= 1'b0;
            err_addr_q     <= '0;
            err_cnt_q      <= '0;
            store_cnt_q    <= '0;
        end else begin
            misalign_err_q <= misalign_err_d;
            err_addr_q     <= err_addr_d;
            err_cnt_q      <= err_cnt_d;
            store_cnt_q    <= store_cnt_d;
        end
    end

    always_comb begin
        word_rd  = mem_q[idx];
        half_rd  = Addr_in[1] ? word_rd[31:16] : word_rd[15:0];
        byte_rd  = word_rd[{Addr_in[1:0], 3'b000} +: 8];
        Data_out = word_rd;
        case (dm_ctrl)
            CTRL_H:  Data_out = {{16{half_rd[15]}}, half_rd};
            CTRL_HU: Data_out = {16'd0, half_rd};
            CTRL_B:  Data_out = {{24{byte_rd[7]}}, byte_rd};
            CTRL_BU: Data_out = {24'd0, byte_rd};
            default: Data_out = word_rd;
        endcase
    end

    assign misalign_err = misalign_err_q;
    assign err_addr     = err_addr_q;
    assign err_cnt      = err_cnt_q;
    assign store_cnt    = store_cnt_q;

endmodule
